// File: rtl/vga_timing_if.sv
// Raster/pixel bundle between the VGA timing generator and the shape renderers.
// The timing generator is the master; renderers read coordinates and return colour.
interface vga_timing_if;
    logic [10:0] hc;
    logic [10:0] vc;
    logic        vidon;
    logic        vblank_tick;
    logic [11:0] pix_in;
    logic [11:0] vga_rgb;
    logic        vga_hs;
    logic        vga_vs;

    modport master (
        output hc, vc, vidon, vblank_tick, vga_rgb, vga_hs, vga_vs,
        input  pix_in
    );

    modport slave (
        input  hc, vc, vidon, vblank_tick, vga_rgb, vga_hs, vga_vs,
        output pix_in
    );
endinterface

// File: rtl/vga_timing.sv
// 800x600@60 raster generator: free-running hc/vc counters, active-video flag,
// frame tick, and sync/colour re-timing against the renderer latency PIPE.
module vga_timing #(
    parameter int HVIS = 800,
    parameter int HFP  = 40,
    parameter int HSW  = 128,
    parameter int HBP  = 88,
    parameter int VVIS = 600,
    parameter int VFP  = 1,
    parameter int VSW  = 4,
    parameter int VBP  = 23,
    parameter int PIPE = 2
) (
    input  logic         clk_40m,
    input  logic         rst_n,
    vga_timing_if.master bus
);
    localparam int HTOTAL = HVIS + HFP + HSW + HBP;
    localparam int VTOTAL = VVIS + VFP + VSW + VBP;

    localparam logic [10:0] H_LAST   = 11'(HTOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(VTOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(HVIS);
    localparam logic [10:0] V_VIS    = 11'(VVIS);
    localparam logic [10:0] HS_START = 11'(HVIS + HFP);
    localparam logic [10:0] HS_END   = 11'(HVIS + HFP + HSW);
    localparam logic [10:0] VS_START = 11'(VVIS + VFP);
    localparam logic [10:0] VS_END   = 11'(VVIS + VFP + VSW);

    typedef struct packed {
        logic vid;
        logic hs;
        logic vs;
    } tap_t;

    logic [10:0] r_hc;
    logic [10:0] r_vc;
    logic [10:0] w_hc_nxt;
    logic [10:0] w_vc_nxt;
    logic        r_vidon;
    logic        r_tick;
    logic        w_hs_raw;
    logic        w_vs_raw;
    tap_t        w_cur;
    tap_t        w_tap;
    logic [11:0] r_rgb;
    logic        r_hs;
    logic        r_vs;

    always_comb begin
        w_hc_nxt = r_hc + 11'd1;
        w_vc_nxt = r_vc;
        if (r_hc == H_LAST) begin
            w_hc_nxt = '0;
            w_vc_nxt = (r_vc == V_LAST) ? '0 : r_vc + 11'd1;
        end
    end

    // Flags are decoded from the next count so they land in the same cycle as hc/vc.
    always_ff @(posedge clk_40m or negedge rst_n) begin
        if (!rst_n) begin
            r_hc    <= H_LAST;
            r_vc    <= V_LAST;
            r_vidon <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_hc    <= w_hc_nxt;
            r_vc    <= w_vc_nxt;
            r_vidon <= (w_hc_nxt < H_VIS) && (w_vc_nxt < V_VIS);
            r_tick  <= (w_hc_nxt == 11'd0) && (w_vc_nxt == V_VIS);
        end
    end

    assign w_hs_raw = (r_hc >= HS_START) && (r_hc < HS_END);
    assign w_vs_raw = (r_vc >= VS_START) && (r_vc < VS_END);
    assign w_cur    = '{vid: r_vidon, hs: w_hs_raw, vs: w_vs_raw};

    generate
        if (PIPE == 0) begin : g_nodly
            assign w_tap = w_cur;
        end else begin : g_dly
            tap_t r_dly [PIPE];

            always_ff @(posedge clk_40m or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE; i++) r_dly[i] <= '0;
                end else begin
                    r_dly[0] <= w_cur;
                    for (int i = 1; i < PIPE; i++) r_dly[i] <= r_dly[i-1];
                end
            end

            assign w_tap = r_dly[PIPE-1];
        end
    endgenerate

    // The tap is aligned with pix_in; colour is forced black outside active video.
    always_ff @(posedge clk_40m or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb <= '0;
            r_hs  <= 1'b0;
            r_vs  <= 1'b0;
        end else begin
            r_rgb <= w_tap.vid ? bus.pix_in : 12'h000;
            r_hs  <= w_tap.hs;
            r_vs  <= w_tap.vs;
        end
    end

    assign bus.hc          = r_hc;
    assign bus.vc          = r_vc;
    assign bus.vidon       = r_vidon;
    assign bus.vblank_tick = r_tick;
    assign bus.vga_rgb     = r_rgb;
    assign bus.vga_hs      = r_hs;
    assign bus.vga_vs      = r_vs;
endmodule

// File: tb/tb_vga_timing.sv
// Directed-vector scoreboard for vga_timing: a full-size instance for line-level
// checks and a reduced-geometry instance for frame, vblank and mid-frame reset.
module tb_vga_timing;
    typedef enum int {S_HC, S_VC, S_VIDON, S_TICK, S_RGB, S_HS, S_VS,
                      C_VID, C_HS, C_VS, C_TICK, C_RGB} sel_e;
    typedef struct {
        int   dut;
        int   cyc;
        sel_e sel;
        int   exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst0_n = 1'b1;
    logic rst1_n = 1'b1;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   t[2];
    int   cvid[2], chs[2], cvs[2], ctick[2], crgb[2];

    always #5 clk = ~clk;

    vga_timing_if if0();
    vga_timing_if if1();

    vga_timing u_dut0 (
        .clk_40m (clk),
        .rst_n   (rst0_n),
        .bus     (if0.master)
    );

    // Reduced geometry: HTOTAL=32 (hsync hc 20..25), VTOTAL=20 (vsync vc 13..15).
    vga_timing #(
        .HVIS(16), .HFP(4), .HSW(6), .HBP(6),
        .VVIS(12), .VFP(1), .VSW(3), .VBP(4), .PIPE(2)
    ) u_dut1 (
        .clk_40m (clk),
        .rst_n   (rst1_n),
        .bus     (if1.master)
    );

    // Renderer stand-in: FFF for coordinate hc==10 appears two cycles later (hc==12),
    // and FFF from hc>=790 onward so the blank region sees a non-zero input.
    assign if0.pix_in = (if0.hc == 11'd12 || if0.hc >= 11'd790) ? 12'hFFF : 12'hABC;

    always @(negedge clk) begin
        if (if0.vidon !== ((if0.hc < 11'd800) && (if0.vc < 11'd600))) begin
            n_bad++;
            $display("FAIL dut0 vidon incoherent: hc=%0d vc=%0d vidon=%b", if0.hc, if0.vc, if0.vidon);
        end
        if (if0.vblank_tick !== ((if0.hc == 11'd0) && (if0.vc == 11'd600))) begin
            n_bad++;
            $display("FAIL dut0 tick incoherent: hc=%0d vc=%0d", if0.hc, if0.vc);
        end
        if (if1.vidon !== ((if1.hc < 11'd16) && (if1.vc < 11'd12))) begin
            n_bad++;
            $display("FAIL dut1 vidon incoherent: hc=%0d vc=%0d vidon=%b", if1.hc, if1.vc, if1.vidon);
        end
        if (if1.vblank_tick !== ((if1.hc == 11'd0) && (if1.vc == 11'd12))) begin
            n_bad++;
            $display("FAIL dut1 tick incoherent: hc=%0d vc=%0d", if1.hc, if1.vc);
        end
        if ((if0.hc > 11'd1055) || (if0.vc > 11'd627) || (if1.hc > 11'd31) || (if1.vc > 11'd19)) begin
            n_bad++;
            $display("FAIL counter out of range");
        end
    end

    task automatic pv(input int d, input int c, input sel_e s, input int e);
        vq.push_back('{dut: d, cyc: c, sel: s, exp: e});
    endtask

    function automatic int smp(input int d, input sel_e s);
        int r;
        r = 0;
        case (s)
            S_HC:    r = (d == 0) ? int'(if0.hc)          : int'(if1.hc);
            S_VC:    r = (d == 0) ? int'(if0.vc)          : int'(if1.vc);
            S_VIDON: r = (d == 0) ? int'(if0.vidon)       : int'(if1.vidon);
            S_TICK:  r = (d == 0) ? int'(if0.vblank_tick) : int'(if1.vblank_tick);
            S_RGB:   r = (d == 0) ? int'(if0.vga_rgb)     : int'(if1.vga_rgb);
            S_HS:    r = (d == 0) ? int'(if0.vga_hs)      : int'(if1.vga_hs);
            S_VS:    r = (d == 0) ? int'(if0.vga_vs)      : int'(if1.vga_vs);
            C_VID:   r = cvid[d];
            C_HS:    r = chs[d];
            C_VS:    r = cvs[d];
            C_TICK:  r = ctick[d];
            C_RGB:   r = crgb[d];
            default: r = -1;
        endcase
        return r;
    endfunction

    // Monitor: t = cycles since the first edge after reset release (-1 while in reset).
    initial begin
        vec_t v;
        int   got;
        logic rs;
        for (int d = 0; d < 2; d++) begin
            t[d] = -1; cvid[d] = 0; chs[d] = 0; cvs[d] = 0; ctick[d] = 0; crgb[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                rs = (d == 0) ? rst0_n : rst1_n;
                if (!rs) begin
                    t[d] = -1; cvid[d] = 0; chs[d] = 0; cvs[d] = 0; ctick[d] = 0; crgb[d] = 0;
                end else begin
                    t[d]++;
                    cvid[d]  += smp(d, S_VIDON);
                    chs[d]   += smp(d, S_HS);
                    cvs[d]   += smp(d, S_VS);
                    ctick[d] += smp(d, S_TICK);
                    crgb[d]  += (smp(d, S_RGB) != 0) ? 1 : 0;
                end
            end
            while (vq.size() > 0 && vq[0].cyc == t[vq[0].dut]) begin
                v   = vq.pop_front();
                got = smp(v.dut, v.sel);
                n_vec++;
                if (got !== v.exp) begin
                    n_bad++;
                    $display("FAIL %s dut%0d t=%0d: got %0h, expected %0h",
                             v.sel.name(), v.dut, v.cyc, got, v.exp);
                end
            end
        end
    end

    task automatic drain(input int budget);
        for (int i = 0; i < budget && vq.size() != 0; i++) @(negedge clk);
        while (vq.size() != 0) begin
            vec_t v;
            v = vq.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s dut%0d t=%0d: vector never reached, expected %0h",
                     v.sel.name(), v.dut, v.cyc, v.exp);
        end
    endtask

    initial begin
        if1.pix_in = 12'hABC;

        // Full-size instance: reset state, first two lines.
        pv(0, -1, S_HC, 1055); pv(0, -1, S_VC, 627); pv(0, -1, S_VIDON, 0);
        pv(0, -1, S_TICK, 0);  pv(0, -1, S_RGB, 0);  pv(0, -1, S_HS, 0); pv(0, -1, S_VS, 0);
        pv(0, 0, S_HC, 0); pv(0, 0, S_VC, 0); pv(0, 0, S_VIDON, 1); pv(0, 0, S_TICK, 0);
        pv(0, 0, S_RGB, 0);
        pv(0, 2, S_RGB, 'h000);  pv(0, 3, S_RGB, 'hABC);
        pv(0, 12, S_RGB, 'hABC); pv(0, 13, S_RGB, 'hFFF); pv(0, 14, S_RGB, 'hABC);
        pv(0, 799, S_VIDON, 1);  pv(0, 800, S_VIDON, 0); pv(0, 800, S_HC, 800);
        pv(0, 802, S_RGB, 'hFFF); pv(0, 803, S_RGB, 'h000);
        pv(0, 842, S_HS, 0); pv(0, 843, S_HS, 1); pv(0, 900, S_RGB, 'h000);
        pv(0, 970, S_HS, 1); pv(0, 971, S_HS, 0);
        pv(0, 1055, S_HC, 1055); pv(0, 1055, S_VC, 0);
        pv(0, 1055, C_VID, 800); pv(0, 1055, C_HS, 128);
        pv(0, 1056, S_HC, 0); pv(0, 1056, S_VC, 1); pv(0, 1056, S_VIDON, 1);
        pv(0, 1056, S_RGB, 'h000); pv(0, 1059, S_RGB, 'hABC);
        pv(0, 2111, C_VID, 1600); pv(0, 2111, C_HS, 256);
        pv(0, 2111, C_VS, 0); pv(0, 2111, C_TICK, 0);

        #1 rst0_n = 1'b0; rst1_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst0_n = 1'b1;
        drain(3000);

        // Reduced instance, first frame (640 cycles) up to the mid-frame reset.
        pv(1, -1, S_HC, 31); pv(1, -1, S_VC, 19); pv(1, -1, S_VIDON, 0);
        pv(1, -1, S_RGB, 0); pv(1, -1, S_HS, 0);  pv(1, -1, S_VS, 0);
        pv(1, 0, S_HC, 0); pv(1, 0, S_VC, 0); pv(1, 0, S_VIDON, 1);
        pv(1, 3, S_RGB, 'hABC);
        pv(1, 15, S_VIDON, 1); pv(1, 16, S_VIDON, 0);
        pv(1, 18, S_RGB, 'hABC); pv(1, 19, S_RGB, 'h000);
        pv(1, 22, S_HS, 0); pv(1, 23, S_HS, 1); pv(1, 28, S_HS, 1); pv(1, 29, S_HS, 0);
        pv(1, 31, S_HC, 31); pv(1, 31, S_VC, 0); pv(1, 31, C_VID, 16); pv(1, 31, C_HS, 6);
        pv(1, 355, S_RGB, 'hABC);
        pv(1, 383, S_TICK, 0); pv(1, 384, S_TICK, 1); pv(1, 384, S_VC, 12);
        pv(1, 384, S_HC, 0);   pv(1, 384, S_VIDON, 0); pv(1, 385, S_TICK, 0);
        pv(1, 387, S_RGB, 'h000);
        pv(1, 418, S_VS, 0); pv(1, 419, S_VS, 1); pv(1, 514, S_VS, 1); pv(1, 515, S_VS, 0);
        pv(1, 639, S_HC, 31); pv(1, 639, S_VC, 19); pv(1, 639, S_VIDON, 0);
        pv(1, 639, C_TICK, 1); pv(1, 639, C_VS, 96); pv(1, 639, C_VID, 192);
        pv(1, 639, C_RGB, 192);
        pv(1, 640, S_HC, 0); pv(1, 640, S_VC, 0); pv(1, 640, S_VIDON, 1);
        pv(1, 856, S_HS, 1); pv(1, 856, S_HC, 24); pv(1, 856, S_VC, 6);
        // Mid-frame reset lands inside hsync; the next negedge is still before any edge.
        pv(1, -1, S_HS, 0); pv(1, -1, S_HC, 31); pv(1, -1, S_VC, 19);
        pv(1, -1, S_VIDON, 0); pv(1, -1, S_RGB, 0); pv(1, -1, S_VS, 0); pv(1, -1, S_TICK, 0);
        // Frame after the mid-frame reset repeats the post-reset frame.
        pv(1, 0, S_HC, 0); pv(1, 0, S_VC, 0); pv(1, 0, S_VIDON, 1);
        pv(1, 23, S_HS, 1); pv(1, 384, S_TICK, 1);
        pv(1, 418, S_VS, 0); pv(1, 419, S_VS, 1); pv(1, 514, S_VS, 1); pv(1, 515, S_VS, 0);
        pv(1, 639, C_TICK, 1); pv(1, 639, C_VS, 96); pv(1, 639, C_VID, 192);
        pv(1, 639, C_HS, 120);
        pv(1, 640, S_HC, 0); pv(1, 640, S_VC, 0); pv(1, 640, S_VIDON, 1);

        @(negedge clk);
        #1 rst1_n = 1'b1;
        repeat (858) @(posedge clk);
        #2 rst1_n = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst1_n = 1'b1;
        drain(1500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        if (n_bad == 0) $display("PASS");
        else            $display("FAIL");
        $finish;
    end
endmodule
